// File: rtl/pe_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : pe_alu_seq
// Purpose  : Per-PE sequential ALU: single-cycle add, shift-add unsigned multiply
//            with a held completion level for the PE controller.
// Revision : 1.0
// ============================================================================
module pe_alu_seq #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        operation,
   input  logic [DATA_W-1:0] douta,
   input  logic [DATA_W-1:0] doutb,
   output logic [DATA_W-1:0] result,
   output logic              ovf,
   output logic              op_done,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD_EX = 2'd1,
      MUL_EX = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [1:0]       OP_NONE = 2'b00;
   localparam logic [1:0]       OP_ADD  = 2'b01;
   localparam logic [1:0]       OP_MUL  = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t                state_q, state_d;
   logic [DATA_W-1:0]     op_a_q, op_a_d;
   logic [DATA_W-1:0]     op_b_q, op_b_d;
   logic [2*DATA_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]     result_q, result_d;
   logic                  ovf_q, ovf_d;
   logic                  op_done_q, op_done_d;
   logic                  busy_q, busy_d;

   logic [DATA_W:0]       sum;
   logic [DATA_W-1:0]     b_shift;
   logic [2*DATA_W-1:0]   partial;
   logic [2*DATA_W-1:0]   acc_next;

   assign sum      = {1'b0, op_a_q} + {1'b0, op_b_q};
   assign b_shift  = op_b_q >> cnt_q;
   assign partial  = b_shift[0] ? ({{DATA_W{1'b0}}, op_a_q} << cnt_q) : '0;
   assign acc_next = acc_q + partial;

   always_comb begin
      state_d   = state_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      ovf_d     = ovf_q;
      op_done_d = op_done_q;

      case (state_q)
         IDLE: begin
            op_done_d = 1'b0;
            if (operation == OP_ADD) begin
               op_a_d  = douta;
               op_b_d  = doutb;
               state_d = ADD_EX;
            end else if (operation == OP_MUL) begin
               op_a_d  = douta;
               op_b_d  = doutb;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL_EX;
            end
         end
         ADD_EX: begin
            if (operation == OP_NONE) begin
               state_d = IDLE;
            end else begin
               result_d  = sum[DATA_W-1:0];
               ovf_d     = sum[DATA_W];
               op_done_d = 1'b1;
               state_d   = DONE;
            end
         end
         MUL_EX: begin
            if (operation == OP_NONE) begin
               state_d = IDLE;
            end else begin
               acc_d = acc_next;
               cnt_d = cnt_q + 1'b1;
               // Last partial product is folded in on the same edge that publishes the result.
               if (cnt_q == CNT_LAST) begin
                  result_d  = acc_next[DATA_W-1:0];
                  ovf_d     = |acc_next[2*DATA_W-1:DATA_W];
                  op_done_d = 1'b1;
                  state_d   = DONE;
               end
            end
         end
         DONE: begin
            if (operation == OP_NONE) begin
               op_done_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == ADD_EX) || (state_d == MUL_EX);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         op_a_q    <= '0;
         op_b_q    <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         result_q  <= '0;
         ovf_q     <= 1'b0;
         op_done_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_a_q    <= op_a_d;
         op_b_q    <= op_b_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         result_q  <= result_d;
         ovf_q     <= ovf_d;
         op_done_q <= op_done_d;
         busy_q    <= busy_d;
      end
   end

   assign result  = result_q;
   assign ovf     = ovf_q;
   assign op_done = op_done_q;
   assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_alu_seq
// Purpose  : Directed self-checking bench for pe_alu_seq (DATA_W = 8).
// Revision : 1.0
// ============================================================================
module tb_pe_alu_seq;

   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [1:0]        operation;
   logic [DATA_W-1:0] douta;
   logic [DATA_W-1:0] doutb;
   logic [DATA_W-1:0] result;
   logic              ovf;
   logic              op_done;
   logic              busy;

   int errors = 0;
   int checks = 0;

   pe_alu_seq #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .operation (operation),
      .douta     (douta),
      .doutb     (doutb),
      .result    (result),
      .ovf       (ovf),
      .op_done   (op_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      operation = 2'b00;
      douta     = '0;
      doutb     = '0;
      tick();
      tick();
      checks++;
      if ({result, ovf, op_done, busy} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got result=%h ovf=%b op_done=%b busy=%b, want all 0",
                  result, ovf, op_done, busy);
      end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_add();
      douta     = 8'd200;
      doutb     = 8'd100;
      operation = 2'b01;
      tick();                            // edge 0
      checks++;
      if (busy !== 1'b1 || op_done !== 1'b0) begin
         errors++;
         $display("FAIL add_edge0: got busy=%b op_done=%b, want busy=1 op_done=0", busy, op_done);
      end
      tick();                            // edge 1
      checks++;
      if (op_done !== 1'b1 || result !== 8'h2C || ovf !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL add_done: got op_done=%b result=%h ovf=%b busy=%b, want 1 2c 1 0",
                  op_done, result, ovf, busy);
      end
      operation = 2'b10;                 // change in DONE must not restart
      douta     = 8'd1;
      tick();
      checks++;
      if (op_done !== 1'b1 || busy !== 1'b0 || result !== 8'h2C) begin
         errors++;
         $display("FAIL add_hold: got op_done=%b busy=%b result=%h, want 1 0 2c",
                  op_done, busy, result);
      end
      operation = 2'b00;
      tick();
      checks++;
      if (op_done !== 1'b0 || result !== 8'h2C || ovf !== 1'b1) begin
         errors++;
         $display("FAIL add_release: got op_done=%b result=%h ovf=%b, want 0 2c 1",
                  op_done, result, ovf);
      end
   endtask

   // Runs one multiply with exact latency checks; scramble toggles operand inputs during MUL_EX.
   task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_res, input logic exp_ovf,
                          input bit scramble, input string name);
      int busy_cycles;
      douta     = a;
      doutb     = b;
      operation = 2'b10;
      busy_cycles = 0;
      tick();                            // edge 0
      for (int i = 1; i < DATA_W; i++) begin
         if (busy === 1'b1 && op_done === 1'b0) busy_cycles++;
         if (scramble) begin
            douta = 8'(i * 37 + 5);
            doutb = 8'(i * 91 + 3);
         end
         tick();
      end
      if (busy === 1'b1 && op_done === 1'b0) busy_cycles++;
      checks++;
      if (busy_cycles !== DATA_W) begin
         errors++;
         $display("FAIL %s_busy: got %0d busy cycles, want %0d", name, busy_cycles, DATA_W);
      end
      tick();                            // edge DATA_W
      checks++;
      if (op_done !== 1'b1 || result !== exp_res || ovf !== exp_ovf || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_done: got op_done=%b result=%h ovf=%b busy=%b, want 1 %h %b 0",
                  name, op_done, result, ovf, busy, exp_res, exp_ovf);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (op_done !== 1'b1 || busy !== 1'b0 || result !== exp_res) begin
            errors++;
            $display("FAIL %s_hold%0d: got op_done=%b busy=%b result=%h, want 1 0 %h",
                     name, i, op_done, busy, result, exp_res);
         end
      end
      operation = 2'b00;
      tick();
      checks++;
      if (op_done !== 1'b0 || result !== exp_res) begin
         errors++;
         $display("FAIL %s_release: got op_done=%b result=%h, want 0 %h",
                  name, op_done, result, exp_res);
      end
   endtask

   task automatic test_mul();
      run_mul(8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, "mul_13x11");
   endtask

   task automatic test_mul_ovf();
      run_mul(8'd20,  8'd20,  8'h90, 1'b1, 1'b0, "mul_20x20");
      run_mul(8'd255, 8'd255, 8'h01, 1'b1, 1'b0, "mul_255x255");
      run_mul(8'd0,   8'd77,  8'h00, 1'b0, 1'b0, "mul_0x77");
   endtask

   task automatic test_isolation();
      run_mul(8'd6, 8'd7, 8'd42, 1'b0, 1'b1, "mul_isolation");
   endtask

   task automatic test_abort();
      douta     = 8'd9;
      doutb     = 8'd9;
      operation = 2'b10;
      tick();
      tick();
      tick();
      operation = 2'b00;
      tick();
      checks++;
      if (busy !== 1'b0 || op_done !== 1'b0 || result !== 8'd42) begin
         errors++;
         $display("FAIL abort_mul: got busy=%b op_done=%b result=%h, want 0 0 2a",
                  busy, op_done, result);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if (op_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done%0d: got op_done=%b, want 0", i, op_done);
         end
      end
      operation = 2'b01;
      tick();
      operation = 2'b00;
      tick();
      checks++;
      if (busy !== 1'b0 || op_done !== 1'b0 || result !== 8'd42) begin
         errors++;
         $display("FAIL abort_add: got busy=%b op_done=%b result=%h, want 0 0 2a",
                  busy, op_done, result);
      end
      operation = 2'b11;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0 || op_done !== 1'b0 || result !== 8'd42) begin
         errors++;
         $display("FAIL reserved_op: got busy=%b op_done=%b result=%h, want 0 0 2a",
                  busy, op_done, result);
      end
      operation = 2'b00;
      tick();
   endtask

   task automatic test_reset_mid_op();
      douta     = 8'd5;
      doutb     = 8'd5;
      operation = 2'b10;
      tick();
      tick();
      tick();
      reset_n = 1'b0;
      tick();
      checks++;
      if ({result, ovf, op_done, busy} !== 11'd0) begin
         errors++;
         $display("FAIL reset_mid_mul: got result=%h ovf=%b op_done=%b busy=%b, want all 0",
                  result, ovf, op_done, busy);
      end
      reset_n   = 1'b1;
      operation = 2'b00;
      tick();
      douta     = 8'd3;
      doutb     = 8'd4;
      operation = 2'b01;
      tick();
      checks++;
      if (op_done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL post_reset_add_edge0: got op_done=%b busy=%b, want 0 1", op_done, busy);
      end
      tick();
      checks++;
      if (op_done !== 1'b1 || result !== 8'd7 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_add: got op_done=%b result=%h ovf=%b, want 1 07 0",
                  op_done, result, ovf);
      end
      operation = 2'b00;
      tick();
   endtask

   initial begin
      test_reset();
      test_add();
      test_mul();
      test_mul_ovf();
      test_isolation();
      test_abort();
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pe_alu_seq.md
Name: pe_alu_seq

Overview:
- Per-PE arithmetic unit sitting directly downstream of the PE controller's `operation` output.
- It consumes the two RAM read ports (port A and port B data) and the `operation` command. It then executes an add (single cycle) or an unsigned multiply (shift-add, one bit per cycle).
- It returns a held `op_done` level and a stable result, which the controller writes back to RAM through port A.
- `op_done` is a level that holds until the controller drops `operation`. This suits the controller, which registers `op_done` before acting on it.

Parameters:
- DATA_W, 8, operand and result width in bits (2..16).
- CNT_W, 4, width of the multiply iteration counter; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- operation  input  2  command from controller: 00 none, 01 add, 10 multiply, 11 reserved.
- douta  input  DATA_W  RAM port A read data (operand A).
- doutb  input  DATA_W  RAM port B read data (operand B).
- result  output  DATA_W  registered result, low DATA_W bits of sum or product.
- ovf  output  1  registered overflow: add carry-out, or any nonzero product bit above DATA_W-1.
- op_done  output  1  registered completion level.
- busy  output  1  high in ADD_EX or MUL_EX.

Behaviour:
- Synchronous reset (reset_n low at a clk edge):
  - state = IDLE; result, ovf, op_done, busy = 0.
  - Operand registers, accumulator and counter = 0.
  - Reset mid-operation abandons the operation with no op_done pulse.
- States: IDLE, ADD_EX, MUL_EX, DONE. All outputs come from registers; there is no combinational path from `operation` to outputs.
- IDLE:
  - operation==01: capture douta/doutb into opA/opB, go ADD_EX.
  - operation==10: capture opA/opB, clear the 2*DATA_W accumulator, counter = 0, go MUL_EX.
  - operation==00 or 11: stay IDLE; result/ovf hold their previous values.
- ADD_EX (1 cycle):
  - sum = opA + opB, computed DATA_W+1 bits wide.
  - result = sum[DATA_W-1:0]; ovf = sum[DATA_W]; op_done = 1; go DONE.
- MUL_EX (DATA_W cycles):
  - Each cycle: if opB[counter] is 1, accumulator += opA << counter; counter += 1.
  - On the cycle counter == DATA_W-1, the final partial product is included and the register update uses the completed product:
    - result = product[DATA_W-1:0]
    - ovf = |product[2*DATA_W-1:DATA_W]
    - op_done = 1; go DONE.
  - Arithmetic is unsigned; the full 2*DATA_W product is kept internally.
- Latency, counted from the first edge at which IDLE samples a valid operation (edge 0):
  - add: op_done high after edge 1.
  - multiply: op_done high after edge DATA_W (8 for the default).
- DONE:
  - op_done held 1; result/ovf held stable.
  - Leaves to IDLE on the first edge sampling operation==00; op_done clears on that same edge. result/ovf keep their value after op_done clears.
  - While operation stays nonzero (the controller's registered-op_done latency), DONE holds. No restart occurs even if `operation` changes value; a new command needs operation to pass through 00 first.
- Abort: operation==00 sampled in ADD_EX or MUL_EX → go IDLE; op_done stays 0; result/ovf unchanged.
- Operands are captured in IDLE only. douta/doutb changes during ADD_EX/MUL_EX have no effect.
- Edge cases:
  - Multiply by 0 → result 0, ovf 0, full DATA_W-cycle latency.
  - Max operands (DATA_W=8): 255*255 → result 0x01, ovf 1.
  - 255+1 → result 0x00, ovf 1.

Test Plan:
- Add: douta=200, doutb=100, operation=01 held until op_done, then 00 → op_done rises 1 cycle after start with result=0x2C, ovf=1; op_done falls one edge after operation=00; result stays 0x2C.
- Multiply: douta=13, doutb=11, operation=10 → busy for 8 cycles; op_done rises after edge 8 with result=0x8F, ovf=0; held for 3 extra cycles of operation=10 with no restart.
- Multiply overflow: 20*20 → result=0x90, ovf=1. Then 255*255 → result=0x01, ovf=1. Then 0*77 → result=0, ovf=0.
- Abort/reserved: operation=10 dropped to 00 after 3 cycles → IDLE, op_done never asserts, result holds the previous value. operation=11 in IDLE → no state change, busy=0.
- Operand isolation: start multiply 6*7, then change douta/doutb every cycle during MUL_EX → result=42.
- Reset: assert reset_n=0 mid-MUL_EX for 1 edge → all outputs 0 next cycle. A subsequent add of 3+4 yields result=7 with normal latency.
